// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle events into visible LED blinks of fixed
// on-time followed by a fixed off-gap, one independent channel per bit of ev.
// Events that arrive during a blink are queued in a saturating counter and
// replayed as further blinks. All timing is in ticks of a shared prescaler.
//
// Handshake: ev has no ready; every cycle with ev[i]=1 is one event and is
// either accepted (started, queued) or silently dropped once the queue is full.
module pulse_stretch #(
    parameter int CDIV      = 50_000,
    parameter int ON_TICKS  = 100,
    parameter int OFF_TICKS = 50,
    parameter int WIDTH     = 1,
    parameter int PEND_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ev,
    output logic [WIDTH-1:0] led,
    output logic [WIDTH-1:0] busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [31:0]       CDIV_LAST = 32'(CDIV - 1);
    localparam logic [15:0]       ON_LAST   = 16'(ON_TICKS - 1);
    localparam logic [15:0]       OFF_LAST  = 16'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    logic [31:0]       pre_cnt;
    logic              tick;

    state_t            state_q  [WIDTH];
    state_t            state_d  [WIDTH];
    logic [15:0]       timer_q  [WIDTH];
    logic [15:0]       timer_d  [WIDTH];
    logic [PEND_W-1:0] pend_q   [WIDTH];
    logic [PEND_W-1:0] pend_d   [WIDTH];
    logic [PEND_W-1:0] pend_inc [WIDTH];

    // Shared free-running prescaler; channels never realign it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == CDIV_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 32'd1;
        end
    end

    assign tick = (pre_cnt == CDIV_LAST);

    // Pending count after this cycle's event, saturating; only busy channels queue.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pend_inc[i] = pend_q[i];
            if (ev[i] && (state_q[i] != IDLE) && (pend_q[i] != PEND_MAX)) begin
                pend_inc[i] = pend_q[i] + 1'b1;
            end
        end
    end

    // Per-channel next state: IDLE starts on ev, ON/GAP advance only on ticks.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            pend_d[i]  = pend_inc[i];
            case (state_q[i])
                IDLE: begin
                    // A tick in this cycle is deliberately not counted.
                    if (ev[i]) begin
                        state_d[i] = ON;
                        timer_d[i] = '0;
                    end
                end
                ON: begin
                    if (tick) begin
                        if (timer_q[i] == ON_LAST) begin
                            state_d[i] = GAP;
                            timer_d[i] = '0;
                        end else begin
                            timer_d[i] = timer_q[i] + 16'd1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (timer_q[i] == OFF_LAST) begin
                            timer_d[i] = '0;
                            // Increment already applied, so an event in this
                            // very cycle is replayed immediately.
                            if (pend_inc[i] != '0) begin
                                state_d[i] = ON;
                                pend_d[i]  = pend_inc[i] - 1'b1;
                            end else begin
                                state_d[i] = IDLE;
                            end
                        end else begin
                            timer_d[i] = timer_q[i] + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    timer_d[i] = '0;
                    pend_d[i]  = '0;
                end
            endcase
        end
    end

    // Channel state registers plus outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
                pend_q[i]  <= '0;
                led[i]     <= 1'b0;
                busy[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                pend_q[i]  <= pend_d[i];
                led[i]     <= (state_d[i] == ON);
                busy[i]    <= (state_d[i] != IDLE);
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: directed vector tables for the timing scenarios,
// a hand-written asynchronous reset sequence, and randomized events checked
// against an interval-arithmetic reference model.
module tb_pulse_stretch;

  localparam int CDIV      = 4;
  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int WIDTH     = 2;
  localparam int PEND_W    = 2;
  localparam int PMAX      = (1 << PEND_W) - 1;
  localparam int NT        = 90;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] led;
  logic [WIDTH-1:0] busy;

  pulse_stretch #(
    .CDIV      (CDIV),
    .ON_TICKS  (ON_TICKS),
    .OFF_TICKS (OFF_TICKS),
    .WIDTH     (WIDTH),
    .PEND_W    (PEND_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ev   (ev),
    .led  (led),
    .busy (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] led;
    logic [WIDTH-1:0] busy;
  } vec_t;

  vec_t tbl [NT];

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: expected {led, busy} for each upcoming cycle
  logic [2*WIDTH-1:0] exp_q[$];

  // reference model state: each channel is a blink interval [start, dec]
  int m_active [WIDTH];
  int m_on_end [WIDTH];
  int m_dec    [WIDTH];
  int m_pend   [WIDTH];
  int mcyc;

  task automatic check(input string name, input int cyc,
                       input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // driver: hold reset two edges, release just after an edge so the next
  // edge is cycle 0
  task automatic do_reset();
    rst = 1'b1;
    ev  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_tbl();
    for (int c = 0; c < NT; c++) begin
      tbl[c].ev   = '0;
      tbl[c].led  = '0;
      tbl[c].busy = '0;
    end
  endtask

  task automatic set_led(input int ch, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) tbl[c].led[ch] = 1'b1;
  endtask

  task automatic set_busy(input int ch, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) tbl[c].busy[ch] = 1'b1;
  endtask

  // Outputs seen in cycle c are those registered at edge c-1.
  task automatic run_table(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      ev = tbl[c].ev;
      check({name, "_led"}, c, led, tbl[c].led);
      check({name, "_busy"}, c, busy, tbl[c].busy);
      @(posedge clk);
      #1;
    end
    ev = '0;
  endtask

  // first tick cycle at or after c (ticks where c % CDIV == CDIV-1)
  function automatic int first_tick(input int c);
    return c + (CDIV - 1) - (c % CDIV);
  endfunction

  task automatic model_reset();
    mcyc = 0;
    for (int i = 0; i < WIDTH; i++) begin
      m_active[i] = 0;
      m_on_end[i] = 0;
      m_dec[i]    = 0;
      m_pend[i]   = 0;
    end
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic model_start(input int i, input int s);
    m_active[i] = 1;
    m_on_end[i] = first_tick(s) + (ON_TICKS - 1) * CDIV;
    m_dec[i]    = m_on_end[i] + OFF_TICKS * CDIV;
  endtask

  // consume ev of cycle mcyc, push expected outputs for cycle mcyc+1
  task automatic model_step(input logic [WIDTH-1:0] e);
    logic [WIDTH-1:0] nl;
    logic [WIDTH-1:0] nb;
    for (int i = 0; i < WIDTH; i++) begin
      if (m_active[i] == 0) begin
        if (e[i]) model_start(i, mcyc + 1);
      end else begin
        if (e[i] && m_pend[i] < PMAX) m_pend[i]++;
        if (mcyc == m_dec[i]) begin
          if (m_pend[i] > 0) begin
            m_pend[i]--;
            model_start(i, mcyc + 1);
          end else begin
            m_active[i] = 0;
          end
        end
      end
      nl[i] = (m_active[i] != 0) && (mcyc + 1 <= m_on_end[i]);
      nb[i] = (m_active[i] != 0);
    end
    exp_q.push_back({nl, nb});
    mcyc++;
  endtask

  initial begin
    logic [2*WIDTH-1:0] e;
    int dens;
    rst = 1'b1;
    ev  = '0;
    dens = 4;

    // single blink on ch0 with an independent ch1 blink started on a tick
    do_reset();
    clear_tbl();
    tbl[0].ev[0] = 1'b1;
    tbl[3].ev[1] = 1'b1;
    set_led(0, 1, 11);
    set_busy(0, 1, 19);
    set_led(1, 4, 15);
    set_busy(1, 4, 23);
    run_table("single", 45);

    // one queued event gives a second blink after the gap
    do_reset();
    clear_tbl();
    tbl[0].ev[0] = 1'b1;
    tbl[5].ev[0] = 1'b1;
    set_led(0, 1, 11);
    set_led(0, 20, 31);
    set_busy(0, 1, 39);
    run_table("queued", 50);

    // saturation: five events, four blinks
    do_reset();
    clear_tbl();
    tbl[2].ev[0] = 1'b1;
    tbl[4].ev[0] = 1'b1;
    tbl[5].ev[0] = 1'b1;
    tbl[6].ev[0] = 1'b1;
    tbl[8].ev[0] = 1'b1;
    set_led(0, 3, 11);
    set_led(0, 20, 31);
    set_led(0, 40, 51);
    set_led(0, 60, 71);
    set_busy(0, 3, 79);
    run_table("saturate", 90);

    // event on the final gap tick goes straight back to ON
    do_reset();
    clear_tbl();
    tbl[0].ev[0]  = 1'b1;
    tbl[19].ev[0] = 1'b1;
    set_led(0, 1, 11);
    set_led(0, 20, 31);
    set_busy(0, 1, 39);
    run_table("gap_edge", 60);

    // asynchronous reset in the middle of ON
    do_reset();
    for (int c = 0; c < 6; c++) begin
      ev = (c == 0) ? 2'b01 : 2'b00;
      @(posedge clk);
      #1;
    end
    ev = '0;
    check("rst_pre_led", 6, led, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("rst_async_led", 6, led, 2'b00);
    check("rst_async_busy", 6, busy, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      check("rst_after_led", c, led, 2'b00);
      check("rst_after_busy", c, busy, 2'b00);
      @(posedge clk);
      #1;
    end

    // randomized events against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) dens = $urandom_range(1, 8);
      for (int i = 0; i < WIDTH; i++) ev[i] = ($urandom_range(0, 15) < dens);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rand_queue cycle %0d: got empty expected entry", c);
      end else begin
        e = exp_q.pop_front();
        check("rand_led", c, led, e[2*WIDTH-1:WIDTH]);
        check("rand_busy", c, busy, e[WIDTH-1:0]);
      end
      model_step(ev);
      @(posedge clk);
      #1;
    end
    ev = '0;

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Per-channel visible-output driver: it turns single-cycle internal events into human-visible LED blinks of fixed on-time, separated by a fixed off-gap. It sits at the output end of the user-I/O path, opposite the button-input conditioning. Events arriving while a blink is in progress are queued in a small saturating counter, so N events give N distinct blinks up to the queue limit. Time is measured in prescaler ticks derived from the system clock.

## Interface

- CDIV, 50_000: clk cycles per tick (≥2)
- ON_TICKS, 100: blink on-time in ticks (1..65535)
- OFF_TICKS, 50: mandatory off-gap after each blink, in ticks (1..65535)
- WIDTH, 1: number of independent channels
- PEND_W, 3: width of each channel's pending-event counter (≥1)

- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ev  input  WIDTH  per-channel event; every clk cycle with ev[i]=1 is one event
- led  output  WIDTH  registered stretched output, 1 = lit
- busy  output  WIDTH  registered, 1 when channel is not IDLE

## Operation

- Shared prescaler: 32-bit counter runs 0..CDIV-1 and wraps. tick=1 in the cycle where the counter equals CDIV-1. One prescaler serves all channels; channels never realign it.
- Each channel has its own FSM (IDLE, ON, GAP), a 16-bit tick timer, and a PEND_W-bit pending count.
- Reset values: prescaler 0; every channel IDLE, timer 0, pending 0; led=0, busy=0.
- IDLE: ev=1 → ON next cycle, timer cleared. tick is ignored in IDLE.
- ON: on each tick the timer increments. On a tick with timer==ON_TICKS-1 → GAP, timer cleared.
- GAP: on each tick the timer increments. On a tick with timer==OFF_TICKS-1, the channel goes to ON (timer cleared) if the pending count after this cycle's increment is nonzero, then decrements pending by 1. Otherwise it goes to IDLE.
- ev=1 in ON or GAP: pending = min(pending+1, 2^PEND_W-1). When ev and a GAP→ON consume occur in the same cycle, the increment is applied first (saturating), then the decrement.
- Events beyond saturation are dropped silently.
- led = (state==ON); busy = (state!=IDLE). Both are registered from the next state.
- A level held on ev counts one event per cycle. Callers supply single-cycle pulses.

## Timing

- ev in IDLE at cycle n → led=1 and busy=1 from cycle n+1.
- A tick in the same cycle as the IDLE→ON transition is not counted. The first counted tick is the first tick while the state register holds ON.
- On-time: between (ON_TICKS-1)·CDIV+1 and ON_TICKS·CDIV cycles, depending on tick phase. Gap: exactly OFF_TICKS·CDIV cycles, because GAP is always entered the cycle after a tick.
- Back-to-back blinks from pending: led falls for exactly OFF_TICKS·CDIV cycles, then rises again.
- rst asserted at any time, including mid-ON: led, busy and all state go to 0 immediately (asynchronous). After release the prescaler restarts at 0 and no queued blink resumes.

## Test plan

Parameters for tests 1-5: CDIV=4, ON_TICKS=3, OFF_TICKS=2, PEND_W=2, WIDTH=2. Cycle 0 is the first edge after rst release, so ticks fall in cycles 3, 7, 11, ...

1. ev[0] pulse in cycle 0 → led[0]=1 in cycles 1-11, 0 from cycle 12; busy[0]=1 in cycles 1-19, 0 from cycle 20.
2. ev[0] pulses in cycles 0 and 5 → first blink as in test 1; second blink with led[0]=1 in cycles 20-31; busy[0]=0 from cycle 40.
3. ev[0] pulses in cycles 2, 4, 5, 6, 8 → pending saturates at 3, so exactly 4 blinks, each separated by an 8-cycle low gap; the fifth event is dropped.
4. ev[0] in cycle 0, rst=1 in cycle 6 (mid-ON) → led[0] and busy[0] fall within the same cycle without a clock edge. After release, no activity without a new ev.
5. ev[1] in cycle 3 (a tick cycle) while ch0 runs test 1 → led[1]=1 in cycles 4-15. Ch0 waveform is unchanged, showing the channels are independent.
6. Single-cycle ev[0] in the cycle of the final GAP tick (e.g. cycle 19 in test 1) → goes straight to ON, led[0]=1 from cycle 20, pending ends at 0, and busy never drops.
